// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch-unit definitions.
//   FILL_W / WIN / SHIFT_W : beat width, decode window, shift vector width
//   LEN_NONE..LEN3         : one-hot predecoded length encodings
//   opc_cls_e, opc_class() : 256-entry opcode length class table
//   pdec_t                 : predecoder result {len, long_op}
package ifu_pkg;

    localparam int FILL_W  = 4;
    localparam int WIN     = 7;
    localparam int SHIFT_W = 8;

    localparam logic [3:0] LEN_NONE = 4'b0001;
    localparam logic [3:0] LEN1     = 4'b0010;
    localparam logic [3:0] LEN2     = 4'b0100;
    localparam logic [3:0] LEN3     = 4'b1000;

    typedef enum logic [1:0] {
        OPC_1B   = 2'd0,
        OPC_2B   = 2'd1,
        OPC_3B   = 2'd2,
        OPC_LONG = 2'd3   // 4/5 bytes or variable length, sized by the ex path
    } opc_cls_e;

    typedef struct packed {
        logic [3:0] len;
        logic       long_op;
    } pdec_t;

    // Undefined / reserved opcodes fall into the default 1-byte class.
    function automatic opc_cls_e opc_class(input logic [7:0] opc);
        opc_cls_e cls;
        cls = OPC_1B;
        case (opc) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9, 8'hbc:
                cls = OPC_2B;
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8],
            8'hbb, 8'hbd, 8'hc0, 8'hc1, 8'hc6, 8'hc7:
                cls = OPC_3B;
            8'haa, 8'hab, 8'hb9, 8'hc4, 8'hc5, 8'hc8, 8'hc9:
                cls = OPC_LONG;
            default:
                cls = OPC_1B;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ibuf_ctl_if.sv
// ibuf_ctl_if: fill path + decode window bundle of the instruction buffer.
//   master : ICU/decode side (drives fill beat, flush, shift)
//   slave  : ibuf_ctl (drives ready, window bytes, valids, predecode, count)
interface ibuf_ctl_if;

    logic [31:0] icu_data;
    logic        icu_vld;
    logic        ibuf_ready;
    logic        iu_flush;
    logic [7:0]  iu_shift_d;
    logic [55:0] ibuf_data;
    logic [6:0]  ibuf_vld;
    logic [3:0]  fetch_len0, fetch_len1, fetch_len2, fetch_len3;
    logic [3:0]  fetch_len4, fetch_len5, fetch_len6;
    logic [6:0]  ibuf_long_op;
    logic [4:0]  ibuf_cnt;

    modport master (
        output icu_data, icu_vld, iu_flush, iu_shift_d,
        input  ibuf_ready, ibuf_data, ibuf_vld, ibuf_long_op, ibuf_cnt,
        input  fetch_len0, fetch_len1, fetch_len2, fetch_len3,
        input  fetch_len4, fetch_len5, fetch_len6
    );

    modport slave (
        input  icu_data, icu_vld, iu_flush, iu_shift_d,
        output ibuf_ready, ibuf_data, ibuf_vld, ibuf_long_op, ibuf_cnt,
        output fetch_len0, fetch_len1, fetch_len2, fetch_len3,
        output fetch_len4, fetch_len5, fetch_len6
    );

endinterface

// File: rtl/opc_len_pdec.sv
// opc_len_pdec: combinational per-byte length predecoder.
//   opc : candidate opcode byte
//   vld : byte is held in the buffer
//   res : {one-hot length, long_op}; invalid and long opcodes report LEN_NONE
module opc_len_pdec
    import ifu_pkg::*;
(
    input  logic [7:0] opc,
    input  logic       vld,
    output pdec_t      res
);

    always_comb begin
        res.len     = LEN_NONE;
        res.long_op = 1'b0;
        if (vld) begin
            case (opc_class(opc))
                OPC_1B:   res.len = LEN1;
                OPC_2B:   res.len = LEN2;
                OPC_3B:   res.len = LEN3;
                OPC_LONG: res.long_op = 1'b1;
                default:  res.len = LEN_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ibuf_ctl.sv
// ibuf_ctl: byte-granular instruction buffer between ICU fill and decode.
//   clk, reset_l : core clock, synchronous active-low reset
//   bus (slave)  : fill beat in (icu_data/icu_vld/ibuf_ready), flush and
//                  one-hot retire amount in, 7-byte window with valids,
//                  one-hot lengths, long_op flags and byte count out.
// Storage is a linear shift queue with byte 0 always the oldest.
module ibuf_ctl
    import ifu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_l,
    ibuf_ctl_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(FILL_W);

    logic [DEPTH*8-1:0] q_r, q_sh, q_nxt;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt, k, k_cl, base;
    logic [3:0]         n_set;
    logic [OFF_W-1:0]   off;
    logic               ready, accept;
    logic [WIN-1:0]     vld;
    pdec_t              pd [WIN];

    // Non-one-hot shift vectors retire nothing.
    always_comb begin
        k     = '0;
        n_set = '0;
        for (int i = 0; i < SHIFT_W; i++) begin
            if (bus.iu_shift_d[i]) begin
                n_set = n_set + 4'd1;
                k     = CNT_W'(i);
            end
        end
        if (n_set != 4'd1) k = '0;
    end

    // Ready looks at the registered count only, so decode's shift never
    // lands in the ICU's timing path.
    assign k_cl   = (k > cnt_r) ? cnt_r : k;
    assign ready  = (cnt_r <= CNT_W'(DEPTH - FILL_W));
    assign accept = bus.icu_vld & ready;
    assign base   = cnt_r - k_cl;
    assign q_sh   = q_r >> {k_cl, 3'b000};

    // Shift first, then drop the beat in right behind the surviving bytes.
    always_comb begin
        q_nxt   = q_sh;
        cnt_nxt = base;
        off     = '0;
        if (accept) begin
            cnt_nxt = base + CNT_W'(FILL_W);
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) >= base) && (CNT_W'(i) < base + CNT_W'(FILL_W))) begin
                    off             = OFF_W'(CNT_W'(i) - base);
                    q_nxt[i*8 +: 8] = bus.icu_data[off*8 +: 8];
                end
            end
        end
        if (bus.iu_flush) cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) cnt_r <= '0;
        else          cnt_r <= cnt_nxt;
    end

    // Byte storage needs no reset: everything at or past cnt is masked.
    always_ff @(posedge clk) begin
        q_r <= q_nxt;
    end

    for (genvar n = 0; n < WIN; n++) begin : g_pdec
        assign vld[n] = (CNT_W'(n) < cnt_r);
        opc_len_pdec u_pdec (
            .opc (q_r[n*8 +: 8]),
            .vld (vld[n]),
            .res (pd[n])
        );
        assign bus.ibuf_long_op[n] = pd[n].long_op;
    end

    assign bus.ibuf_ready = ready;
    assign bus.ibuf_cnt   = cnt_r;
    assign bus.ibuf_vld   = vld;
    assign bus.ibuf_data  = q_r[WIN*8-1:0];
    assign bus.fetch_len0 = pd[0].len;
    assign bus.fetch_len1 = pd[1].len;
    assign bus.fetch_len2 = pd[2].len;
    assign bus.fetch_len3 = pd[3].len;
    assign bus.fetch_len4 = pd[4].len;
    assign bus.fetch_len5 = pd[5].len;
    assign bus.fetch_len6 = pd[6].len;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_l) begin
            assert (n_set == 4'd1)
                else $warning("ibuf_ctl: iu_shift_d not one-hot (%b)", bus.iu_shift_d);
            assert (k <= cnt_r)
                else $warning("ibuf_ctl: shift %0d exceeds held count %0d", k, cnt_r);
        end
    end
`endif

endmodule

// File: tb/tb_ibuf_ctl.sv
module tb_ibuf_ctl;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    ibuf_ctl_if bus ();

    ibuf_ctl #(.DEPTH(16)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    byte unsigned mq[$];   // reference queue, index 0 = oldest

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instruction length in bytes; 0 means handled by the ex path.
    function automatic int ref_len(input bit [7:0] b);
        if (b inside {8'haa, 8'hab, 8'hb9, 8'hc4, 8'hc5, 8'hc8, 8'hc9}) return 0;
        if (b inside {8'h10, 8'h12, 8'ha9, 8'hbc} || (b >= 8'h15 && b <= 8'h19) ||
            (b >= 8'h36 && b <= 8'h3a)) return 2;
        if (b inside {8'h11, 8'h13, 8'h14, 8'h84, 8'hbb, 8'hbd, 8'hc0, 8'hc1, 8'hc6, 8'hc7} ||
            (b >= 8'h99 && b <= 8'ha8) || (b >= 8'hb2 && b <= 8'hb8)) return 3;
        return 1;
    endfunction

    function automatic logic [3:0] dut_len(input int n);
        case (n)
            0: return bus.fetch_len0;
            1: return bus.fetch_len1;
            2: return bus.fetch_len2;
            3: return bus.fetch_len3;
            4: return bus.fetch_len4;
            5: return bus.fetch_len5;
            default: return bus.fetch_len6;
        endcase
    endfunction

    task automatic check_all();
        int sz;
        int l;
        sz = mq.size();
        chk("cnt", bus.ibuf_cnt, sz);
        chk("ready", bus.ibuf_ready, (sz <= 12) ? 1 : 0);
        for (int n = 0; n < 7; n++) begin
            chk($sformatf("vld%0d", n), bus.ibuf_vld[n], (n < sz) ? 1 : 0);
            if (n < sz) begin
                l = ref_len(mq[n]);
                chk($sformatf("data%0d", n), bus.ibuf_data[n*8 +: 8], mq[n]);
                chk($sformatf("len%0d", n), dut_len(n), (l == 0) ? 4'b0001 : 4'(1 << l));
                chk($sformatf("long%0d", n), bus.ibuf_long_op[n], (l == 0) ? 1 : 0);
            end else begin
                chk($sformatf("len%0d", n), dut_len(n), 4'b0001);
                chk($sformatf("long%0d", n), bus.ibuf_long_op[n], 0);
            end
        end
    endtask

    // One clock: drive at negedge, update model at the edge, check at next negedge.
    task automatic cycle(input bit vld, input logic [31:0] d, input bit flush, input int k);
        int sz0;
        int kk;
        bit acc;
        bus.icu_vld    = vld;
        bus.icu_data   = d;
        bus.iu_flush   = flush;
        bus.iu_shift_d = 8'(1 << k);
        sz0 = mq.size();
        acc = vld && (sz0 <= 12);
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
        end else begin
            kk = (k > sz0) ? sz0 : k;
            repeat (kk) void'(mq.pop_front());
            if (acc) for (int j = 0; j < 4; j++) mq.push_back(d[j*8 +: 8]);
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] longs [7];
        longs = '{8'haa, 8'hab, 8'hb9, 8'hc4, 8'hc5, 8'hc8, 8'hc9};
        if ($urandom_range(0, 7) == 0) return longs[$urandom_range(0, 6)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int k;
        int mx;
        logic [31:0] d;
        bus.icu_vld    = 1'b0;
        bus.icu_data   = '0;
        bus.iu_flush   = 1'b0;
        bus.iu_shift_d = 8'b0000_0001;

        // reset and idle
        reset_l = 1'b0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        check_all();
        chk("rst_vld", bus.ibuf_vld, 7'b0);
        chk("rst_len0", bus.fetch_len0, 4'b0001);
        cycle(0, '0, 0, 0);

        // first beat: iadd, bipush, iconst_2, sipush
        cycle(1, 32'h11051060, 0, 0);
        chk("t2_vld", bus.ibuf_vld, 7'b0001111);
        chk("t2_len0", bus.fetch_len0, 4'b0010);
        chk("t2_len1", bus.fetch_len1, 4'b0100);
        chk("t2_len3", bus.fetch_len3, 4'b1000);

        // cnt=8, shift 3 with a same-cycle fill
        cycle(1, 32'h99887766, 0, 0);
        chk("t3_pre", bus.ibuf_cnt, 8);
        d = 32'h04030201;
        begin
            logic [7:0] old3;
            old3 = mq[3];
            cycle(1, d, 0, 3);
            chk("t3_cnt", bus.ibuf_cnt, 9);
            chk("t3_b0", bus.ibuf_data[7:0], old3);
            chk("t3_b5", bus.ibuf_data[47:40], 8'h01);
            chk("t3_b6", bus.ibuf_data[55:48], 8'h02);
        end

        // fill to full, hold, drain
        cycle(0, '0, 1, 0);
        repeat (3) cycle(1, $urandom, 0, 0);
        chk("t4_c12", bus.ibuf_cnt, 12);
        chk("t4_rdy12", bus.ibuf_ready, 1);
        cycle(1, $urandom, 0, 0);
        chk("t4_c16", bus.ibuf_cnt, 16);
        chk("t4_rdy16", bus.ibuf_ready, 0);
        repeat (2) cycle(1, $urandom, 0, 0);
        chk("t4_hold", bus.ibuf_cnt, 16);
        cycle(1, $urandom, 0, 4);
        chk("t4_c12b", bus.ibuf_cnt, 12);
        chk("t4_rdy", bus.ibuf_ready, 1);

        // flush beats shift and fill
        cycle(0, '0, 0, 2);
        chk("t5_c10", bus.ibuf_cnt, 10);
        cycle(1, $urandom, 1, 2);
        chk("t5_cnt", bus.ibuf_cnt, 0);
        chk("t5_vld", bus.ibuf_vld, 7'b0);

        // goto_w at byte 2, then over-shift clamp
        cycle(1, 32'h00c81060, 0, 0);
        chk("t6_len2", bus.fetch_len2, 4'b0001);
        chk("t6_long2", bus.ibuf_long_op[2], 1);
        cycle(0, '0, 0, 2);
        chk("t6_c2", bus.ibuf_cnt, 2);
        cycle(0, '0, 0, 5);
        chk("t6_clamp", bus.ibuf_cnt, 0);

        // random legal traffic
        for (int it = 0; it < 400; it++) begin
            mx = (mq.size() < 7) ? mq.size() : 7;
            k = $urandom_range(0, mx);
            d = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0, k);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
